// File: rtl/riscv_issue.sv
// Instruction issue unit: upstream FIFO feeding a one-per-cycle issue port,
// with an in-order scoreboard that checks every returned ack against what was issued.
module riscv_issue #(
  parameter int REG_WIDTH       = 5,
  parameter int OP_WIDTH        = 7,
  parameter int QUEUE_DEPTH     = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [REG_WIDTH-1:0]               in_rs0,
  input  logic [REG_WIDTH-1:0]               in_rs1,
  input  logic [REG_WIDTH-1:0]               in_rd,
  input  logic [OP_WIDTH-1:0]                in_opcode,
  output logic                               valid,
  output logic [REG_WIDTH-1:0]               rs0,
  output logic [REG_WIDTH-1:0]               rs1,
  output logic [REG_WIDTH-1:0]               rd,
  output logic [OP_WIDTH-1:0]                opcode,
  input  logic                               ack,
  input  logic [REG_WIDTH-1:0]               rs0_out,
  input  logic [REG_WIDTH-1:0]               rs1_out,
  input  logic [REG_WIDTH-1:0]               rd_out,
  input  logic [OP_WIDTH-1:0]                opcode_out,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic [15:0]                        done_count,
  output logic                               err_mismatch,
  output logic                               err_spurious,
  output logic                               idle
);

  localparam int IW  = 3 * REG_WIDTH + OP_WIDTH;
  localparam int QAW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int QCW = $clog2(QUEUE_DEPTH + 1);
  localparam int SAW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SCW = $clog2(MAX_OUTSTANDING + 1);

  // Pointers wrap explicitly so a single-entry scoreboard never leaves slot 0.
  function automatic logic [QAW-1:0] q_inc(input logic [QAW-1:0] p);
    return (p == QAW'(QUEUE_DEPTH - 1)) ? '0 : p + QAW'(1);
  endfunction

  function automatic logic [SAW-1:0] sb_inc(input logic [SAW-1:0] p);
    return (p == SAW'(MAX_OUTSTANDING - 1)) ? '0 : p + SAW'(1);
  endfunction

  logic [IW-1:0]  q_mem  [QUEUE_DEPTH];
  logic [IW-1:0]  sb_mem [MAX_OUTSTANDING];

  logic [QAW-1:0] q_wr_q, q_wr_d, q_rd_q, q_rd_d;
  logic [QCW-1:0] q_cnt_q, q_cnt_d;
  logic [SAW-1:0] sb_wr_q, sb_wr_d, sb_rd_q, sb_rd_d;
  logic [SCW-1:0] sb_cnt_q, sb_cnt_d;
  logic           valid_q, valid_d;
  logic [IW-1:0]  iss_q, iss_d;
  logic [15:0]    done_q, done_d;
  logic           mis_q, mis_d, spur_q, spur_d;

  logic           push, issue, ack_hit, ack_match;
  logic [IW-1:0]  in_instr, ret_instr;

  assign in_instr  = {in_rs0, in_rs1, in_rd, in_opcode};
  assign ret_instr = {rs0_out, rs1_out, rd_out, opcode_out};

  // Ready depends only on the registered count; a same-cycle pop does not open a slot.
  assign in_ready  = (q_cnt_q != QCW'(QUEUE_DEPTH));
  assign push      = in_valid && in_ready;
  assign issue     = (q_cnt_q != '0) && (sb_cnt_q < SCW'(MAX_OUTSTANDING));
  assign ack_hit   = ack && (sb_cnt_q != '0);
  assign ack_match = (ret_instr == sb_mem[sb_rd_q]);

  always_comb begin
    q_wr_d   = push  ? q_inc(q_wr_q)   : q_wr_q;
    q_rd_d   = issue ? q_inc(q_rd_q)   : q_rd_q;
    q_cnt_d  = q_cnt_q + QCW'(push) - QCW'(issue);
    sb_wr_d  = issue   ? sb_inc(sb_wr_q) : sb_wr_q;
    sb_rd_d  = ack_hit ? sb_inc(sb_rd_q) : sb_rd_q;
    sb_cnt_d = sb_cnt_q + SCW'(issue) - SCW'(ack_hit);
    valid_d  = issue;
    iss_d    = issue ? q_mem[q_rd_q] : '0;
    done_d   = (ack_hit && ack_match) ? done_q + 16'd1 : done_q;
    mis_d    = mis_q  || (ack_hit && !ack_match);
    spur_d   = spur_q || (ack && (sb_cnt_q == '0));
  end

  // Storage arrays carry no reset; validity is tracked by the pointers and counts.
  always_ff @(posedge clk) begin
    if (push)  q_mem[q_wr_q]   <= in_instr;
    if (issue) sb_mem[sb_wr_q] <= q_mem[q_rd_q];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_wr_q   <= '0;
      q_rd_q   <= '0;
      q_cnt_q  <= '0;
      sb_wr_q  <= '0;
      sb_rd_q  <= '0;
      sb_cnt_q <= '0;
      valid_q  <= 1'b0;
      iss_q    <= '0;
      done_q   <= '0;
      mis_q    <= 1'b0;
      spur_q   <= 1'b0;
    end else begin
      q_wr_q   <= q_wr_d;
      q_rd_q   <= q_rd_d;
      q_cnt_q  <= q_cnt_d;
      sb_wr_q  <= sb_wr_d;
      sb_rd_q  <= sb_rd_d;
      sb_cnt_q <= sb_cnt_d;
      valid_q  <= valid_d;
      iss_q    <= iss_d;
      done_q   <= done_d;
      mis_q    <= mis_d;
      spur_q   <= spur_d;
    end
  end

  assign valid                  = valid_q;
  assign {rs0, rs1, rd, opcode} = iss_q;
  assign outstanding            = sb_cnt_q;
  assign done_count             = done_q;
  assign err_mismatch           = mis_q;
  assign err_spurious           = spur_q;
  assign idle                   = (q_cnt_q == '0) && (sb_cnt_q == '0);

endmodule

// File: tb/tb_riscv_issue.sv
// Directed bench for riscv_issue: reset, round trip, back-pressure, mismatch,
// spurious ack, simultaneous issue/ack and asynchronous reset mid-flight.
module tb_riscv_issue;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_rs0, in_rs1, in_rd;
  logic [6:0] in_opcode;
  logic       valid;
  logic [4:0] rs0, rs1, rd;
  logic [6:0] opcode;
  logic       ack;
  logic [4:0] rs0_out, rs1_out, rd_out;
  logic [6:0] opcode_out;
  logic [2:0] outstanding;
  logic [15:0] done_count;
  logic       err_mismatch, err_spurious, idle;

  int n_cmp = 0;
  int n_bad = 0;

  riscv_issue #(.REG_WIDTH(5), .OP_WIDTH(7), .QUEUE_DEPTH(4), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs0(in_rs0), .in_rs1(in_rs1), .in_rd(in_rd), .in_opcode(in_opcode),
    .valid(valid), .rs0(rs0), .rs1(rs1), .rd(rd), .opcode(opcode),
    .ack(ack), .rs0_out(rs0_out), .rs1_out(rs1_out), .rd_out(rd_out), .opcode_out(opcode_out),
    .outstanding(outstanding), .done_count(done_count),
    .err_mismatch(err_mismatch), .err_spurious(err_spurious), .idle(idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] d, input logic [6:0] op);
    in_valid = v; in_rs0 = a; in_rs1 = b; in_rd = d; in_opcode = op;
  endtask

  task automatic drive_ack(input logic v, input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] d, input logic [6:0] op);
    ack = v; rs0_out = a; rs1_out = b; rd_out = d; opcode_out = op;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    drive_in(0, 0, 0, 0, 0);
    drive_ack(0, 0, 0, 0, 0);

    // Reset values
    do_reset();
    check("rst_valid", valid, 0);
    check("rst_outstanding", outstanding, 0);
    check("rst_done", done_count, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_idle", idle, 1);
    check("rst_err_mis", err_mismatch, 0);
    check("rst_err_spur", err_spurious, 0);

    // Single round trip
    drive_in(1, 1, 2, 3, 7'h33);
    step();
    drive_in(0, 0, 0, 0, 0);
    check("rt_not_yet_valid", valid, 0);
    step();
    check("rt_valid", valid, 1);
    check("rt_fields", {rs0, rs1, rd, opcode}, {5'd1, 5'd2, 5'd3, 7'h33});
    check("rt_outstanding1", outstanding, 1);
    step();
    check("rt_valid_drop", valid, 0);
    check("rt_fields_zero", {rs0, rs1, rd, opcode}, 0);
    step();
    drive_ack(1, 1, 2, 3, 7'h33);
    step();
    drive_ack(0, 0, 0, 0, 0);
    check("rt_done", done_count, 1);
    check("rt_outstanding0", outstanding, 0);
    check("rt_idle", idle, 1);

    // Back-pressure: 8 pushes with acks withheld
    do_reset();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("bp_ready_%0d", i), in_ready, 1);
      drive_in(1, 5'(i), 5'(i + 8), 5'(i + 16), 7'(8'h10 + i));
      step();
      if (i == 4) check("bp_4th_issue_valid", valid, 1);
    end
    drive_in(0, 0, 0, 0, 0);
    check("bp_in_ready_full", in_ready, 0);
    check("bp_outstanding4", outstanding, 4);
    check("bp_valid_stalled", valid, 0);
    check("bp_not_idle", idle, 0);
    for (int i = 0; i < 8; i++) begin
      drive_ack(1, 5'(i), 5'(i + 8), 5'(i + 16), 7'(8'h10 + i));
      step();
    end
    drive_ack(0, 0, 0, 0, 0);
    check("bp_done8", done_count, 8);
    check("bp_no_mismatch", err_mismatch, 0);
    check("bp_drained_idle", idle, 1);

    // Mismatch: rs1 returned as rs0
    drive_in(1, 5, 9, 1, 7'h13);
    step();
    drive_in(0, 0, 0, 0, 0);
    step();
    check("mm_issued_rs1", rs1, 9);
    drive_ack(1, 5, 5, 1, 7'h13);
    step();
    drive_ack(0, 0, 0, 0, 0);
    check("mm_err", err_mismatch, 1);
    check("mm_done_same", done_count, 8);
    check("mm_outstanding0", outstanding, 0);
    drive_in(1, 4, 6, 8, 7'h03);
    step();
    drive_in(0, 0, 0, 0, 0);
    step();
    drive_ack(1, 4, 6, 8, 7'h03);
    step();
    drive_ack(0, 0, 0, 0, 0);
    check("mm_sticky", err_mismatch, 1);
    check("mm_done_after_good", done_count, 9);

    // Spurious ack while idle
    check("sp_before", err_spurious, 0);
    drive_ack(1, 0, 0, 0, 0);
    step();
    drive_ack(0, 0, 0, 0, 0);
    check("sp_err", err_spurious, 1);
    check("sp_outstanding0", outstanding, 0);
    check("sp_done_same", done_count, 9);

    // Simultaneous issue and ack, then asynchronous reset mid-flight
    drive_in(1, 1, 1, 1, 7'h01);
    step();
    drive_in(1, 2, 2, 2, 7'h02);
    step();
    drive_in(1, 3, 3, 3, 7'h03);
    step();
    drive_in(0, 0, 0, 0, 0);
    check("si_outstanding2", outstanding, 2);
    drive_ack(1, 1, 1, 1, 7'h01);
    step();
    drive_ack(0, 0, 0, 0, 0);
    check("si_outstanding_kept", outstanding, 2);
    check("si_valid_issue", valid, 1);
    check("si_done", done_count, 10);
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_valid", valid, 0);
    check("ar_outstanding", outstanding, 0);
    check("ar_in_ready", in_ready, 1);
    check("ar_done", done_count, 0);
    check("ar_flags", {err_mismatch, err_spurious}, 0);
    step();
    reset_n = 1'b1;
    step();
    check("ar_idle_after", idle, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_issue.md
# riscv_issue

Instruction issue unit that drives the instruction pipeline shift stage from its input side and consumes its output side. It buffers upstream instructions in a small queue and issues at most one per cycle on the `valid/rs0/rs1/rd/opcode` bus. An in-order scoreboard limits the number of instructions in flight and checks every returned `ack` and its fields against what was issued. Sticky error flags and counters feed the testbench and debug status.

## Interface
- `REG_WIDTH`, default 5: width of the register-index fields.
- `OP_WIDTH`, default 7: width of the opcode field.
- `QUEUE_DEPTH`, default 4: number of upstream queue entries, power of 2, at least 2.
- `MAX_OUTSTANDING`, default 4: maximum number of issued-but-unacked instructions, power of 2, at least 1.

Ports:
- `clk`, in, 1: single clock; all state on the rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: upstream instruction present.
- `in_ready`, out, 1: queue can accept an instruction.
- `in_rs0`, `in_rs1`, `in_rd`, in, REG_WIDTH: upstream register fields.
- `in_opcode`, in, OP_WIDTH: upstream opcode.
- `valid`, out, 1: issue strobe to the pipeline.
- `rs0`, `rs1`, `rd`, out, REG_WIDTH: issued fields.
- `opcode`, out, OP_WIDTH: issued opcode.
- `ack`, in, 1: pipeline completion strobe.
- `rs0_out`, `rs1_out`, `rd_out`, in, REG_WIDTH: returned fields.
- `opcode_out`, in, OP_WIDTH: returned opcode.
- `outstanding`, out, $clog2(MAX_OUTSTANDING+1): number of instructions in flight.
- `done_count`, out, 16: number of acks that matched.
- `err_mismatch`, out, 1: sticky; a returned field differed from the issued field.
- `err_spurious`, out, 1: sticky; `ack` arrived with nothing in flight.
- `idle`, out, 1: queue empty and `outstanding` == 0.

## Operation
**Upstream queue**
- Circular FIFO with QUEUE_DEPTH entries.
- `in_ready` = !full, computed from the registered count only.
- A transfer occurs when `in_valid` and `in_ready` are both high.
- When full, `in_ready` stays low even if the queue pops in the same cycle. No flag is raised on a refused transfer.
- No bypass: an entry becomes issuable the cycle after it is written.

**Issue**
- Condition: queue non-empty and `outstanding` < MAX_OUTSTANDING, evaluated on registered state.
- When the condition holds, the next edge registers the head entry onto `rs0`/`rs1`/`rd`/`opcode`, sets `valid`=1, pops the queue and pushes the fields into the scoreboard.
- Otherwise the next edge sets `valid`=0 and drives all issued fields to 0.
- At most one issue per cycle.

**Scoreboard**
- FIFO of MAX_OUTSTANDING entries; `outstanding` equals its occupancy.
- On `ack`=1 with `outstanding` > 0, pop the head and compare all four fields (`rs0_out`, `rs1_out`, `rd_out`, `opcode_out`) against it.
  - All equal: `done_count` increments, wrapping from 0xFFFF to 0.
  - Any field differs: set `err_mismatch`; `done_count` is unchanged.
- On `ack`=1 with `outstanding` == 0: set `err_spurious`; nothing is popped.
- Issue and ack in the same cycle: push and pop both occur; `outstanding` is unchanged.
- Ack is accepted in the cycle immediately after an issue.
- Error flags clear only on reset.

**Reset**
- All outputs are 0 except `in_ready`=1 and `idle`=1.
- Queue and scoreboard pointers are cleared.
- Reset mid-operation discards queued and in-flight entries. The pipeline must be reset at the same time, otherwise stale acks set `err_spurious`.

## Timing
- Instruction accepted at edge t, with the queue previously empty and credit available: `valid`=1 with its fields from edge t+1 through edge t+2.
- Sustained throughput is 1 instruction per cycle when MAX_OUTSTANDING is at least the pipeline round-trip latency. Otherwise the issue rate is limited by credits.
- `outstanding`, `done_count` and the error flags update at the same edge as the issue or ack that causes them.
- `idle` is combinational from registered state.
- Ack fields are sampled only in cycles where `ack`=1.

## Test plan
- **Reset values:** hold `reset_n`=0 for 3 cycles, then release → `valid`=0, `outstanding`=0, `done_count`=0, `in_ready`=1, `idle`=1, both error flags 0.
- **Single round trip:** push rs0=1, rs1=2, rd=3, opcode=0x33 at edge 0 → `valid` and those fields from edge 1; an echoing ack 3 cycles later → `done_count`=1, `outstanding`=0, `idle`=1.
- **Back-pressure:** MAX_OUTSTANDING=4, 8 back-to-back pushes, acks withheld:
  - 4 issues then `valid`=0 and `outstanding`=4;
  - queue fills and `in_ready`=0 after 4 more;
  - releasing acks drains everything in order → `done_count`=8.
- **Mismatch:** return rs1_out=rs0 instead of rs1 for an issued rs0=5, rs1=9 → `err_mismatch`=1 (sticky), `done_count` unchanged, `outstanding` decrements.
- **Spurious ack:** `ack`=1 while idle → `err_spurious`=1, `outstanding` stays 0.
- **Simultaneous events and reset mid-flight:**
  - with `outstanding`=2, issue and ack in the same cycle → `outstanding` stays 2;
  - then assert `reset_n`=0 asynchronously mid-cycle → `valid` and `outstanding` drop to 0 immediately and `in_ready`=1.
